// File: rtl/reg_write_ctrl.sv
// Switch-driven write controller for the register bank: debounces a key press, reads the target
// register, merges the switch byte into one lane and issues a single-cycle write strobe.
module reg_write_ctrl #(
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned ADDR_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [7:0]        sw_byte,
  input  logic              sw_hi,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [7:0]        write_count
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StRead1,
    StRead2,
    StWrite,
    StRelease
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic key_m, key_s;
  logic [7:0] hold_byte;
  logic hold_hi;
  logic capture, load_wr, inc_count;
  logic [DATA_W-1:0] merged;

  // Two-flop synchronizer; idles released so reset never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= key_n;
      key_s <= key_m;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    load_wr   = 1'b0;
    inc_count = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StDebounce;
          cnt_d   = CntW'(1);
        end
      end
      StDebounce: begin
        if (key_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StRead1;
          cnt_d   = '0;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRead1: state_d = StRead2;
      StRead2: begin
        state_d = StWrite;
        load_wr = 1'b1;
      end
      StWrite: begin
        state_d   = StRelease;
        inc_count = 1'b1;
      end
      StRelease: begin
        if (!key_s) begin
          cnt_d = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    merged = rd_data;
    if (hold_hi) merged[DATA_W-1 -: 8] = hold_byte;
    else         merged[7:0]           = hold_byte;
  end

  // rd_addr doubles as the captured-address holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      hold_byte   <= '0;
      hold_hi     <= 1'b0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      write_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        hold_byte <= sw_byte;
        hold_hi   <= sw_hi;
        rd_addr   <= sw_addr;
      end
      if (load_wr) begin
        wr_addr <= rd_addr;
        wr_data <= merged;
      end
      if (inc_count) write_count <= write_count + 8'd1;
    end
  end

  assign wr_en = (state_q == StWrite);
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: behavioural register bank plus a scoreboard of expected writes.
module tb_reg_write_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_n;
  logic [AW-1:0] sw_addr;
  logic [7:0]    sw_byte;
  logic          sw_hi;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic [7:0]    write_count;

  reg_write_ctrl #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .sw_addr(sw_addr),
    .sw_byte(sw_byte),
    .sw_hi(sw_hi),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [7:0]    cnt_before;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] bank[16];
  logic [DW-1:0] ref_mem[16];
  logic [7:0]    exp_cnt;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_wr = 0;
  bit            saw_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Bank: registered read port, write on strobe.
  always @(posedge clk) begin
    rd_data <= bank[rd_addr];
    if (wr_en) bank[wr_addr] <= wr_data;
  end

  always @(negedge clk) begin
    if (busy) saw_busy = 1'b1;
    if (wr_en) begin
      exp_t e;
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_wr_en", 32'(wr_en), 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", 32'(wr_data), 32'(e.data));
        check("count_during_wr", 32'(write_count), 32'(e.cnt_before));
      end
    end
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300 && busy; i++) @(negedge clk);
    check("busy_release", 32'(busy), 32'd0);
  endtask

  // One debounced press; optionally change sw_byte after capture.
  task automatic press(input logic [AW-1:0] a, input logic [7:0] b, input logic hi,
                       input int hold, input bit chg);
    exp_t e;
    e.addr       = a;
    e.data       = hi ? {b, ref_mem[a][7:0]} : {ref_mem[a][DW-1:8], b};
    e.cnt_before = exp_cnt;
    ref_mem[a]   = e.data;
    exp_cnt      = exp_cnt + 8'd1;
    sb.push_back(e);
    @(posedge clk);
    sw_addr = a;
    sw_byte = b;
    sw_hi   = hi;
    key_n   = 1'b0;
    repeat (10) @(posedge clk);
    if (chg) sw_byte = 8'h55;
    repeat (hold - 10) @(posedge clk);
    key_n = 1'b1;
    wait_idle();
    check("write_count", 32'(write_count), 32'(exp_cnt));
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int wr0;
    reset   = 1'b1;
    key_n   = 1'b1;
    sw_addr = '0;
    sw_byte = '0;
    sw_hi   = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      bank[i]    = DW'(16'h1000 + i);
      ref_mem[i] = DW'(16'h1000 + i);
    end
    bank[3] = 16'h1234; ref_mem[3] = 16'h1234;
    bank[5] = 16'h1234; ref_mem[5] = 16'h1234;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_count", 32'(write_count), 32'd0);

    press(4'd3, 8'hAB, 1'b0, 12, 1'b0);
    check("lo_lane_bank", 32'(bank[3]), 32'h12AB);
    press(4'd5, 8'hAB, 1'b1, 12, 1'b0);
    check("hi_lane_bank", 32'(bank[5]), 32'hAB34);

    // Bounce: never reaches four consecutive low samples.
    wr0 = n_wr;
    saw_busy = 1'b0;
    @(posedge clk);
    key_n = 1'b0; repeat (2) @(posedge clk);
    key_n = 1'b1; @(posedge clk);
    key_n = 1'b0; repeat (2) @(posedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    check("bounce_saw_busy", 32'(saw_busy), 32'd1);
    check("bounce_busy", 32'(busy), 32'd0);
    check("bounce_no_wr", 32'(n_wr - wr0), 32'd0);
    check("bounce_count", 32'(write_count), 32'(exp_cnt));

    wr0 = n_wr;
    press(4'd7, 8'hC3, 1'b0, 1000, 1'b1);
    check("long_hold_one_wr", 32'(n_wr - wr0), 32'd1);
    press(4'd7, 8'h9E, 1'b1, 12, 1'b0);
    check("second_press_wr", 32'(n_wr - wr0), 32'd2);

    // Reset while in READ2 (edge 7 after key_n falls).
    wr0 = n_wr;
    @(posedge clk);
    sw_addr = 4'd9; sw_byte = 8'h77; sw_hi = 1'b0;
    key_n = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_rd_addr", 32'(rd_addr), 32'd9);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_rd_addr", 32'(rd_addr), 32'd0);
    check("abort_wr_addr", 32'(wr_addr), 32'd0);
    check("abort_wr_data", 32'(wr_data), 32'd0);
    check("abort_count", 32'(write_count), 32'd0);
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_cnt = '0;
    repeat (10) @(negedge clk);
    check("abort_no_wr", 32'(n_wr - wr0), 32'd0);
    check("abort_bank", 32'(bank[9]), 32'(ref_mem[9]));

    wr0 = n_wr;
    for (int k = 0; k < 256; k++) begin
      press(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 11, 1'b0);
    end
    check("wrap_wr_pulses", 32'(n_wr - wr0), 32'd256);
    check("wrap_count", 32'(write_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_write_ctrl.md
# reg_write_ctrl

Switch-driven write controller for the register bank (`Banco_registradores`) read by the processor top level. The processor top reads two bank registers and shows them on the 7-segment displays; this block is the write side of that path. On a debounced push-button press it captures a register address and a data byte from the switches, reads the target register, and merges the byte into the upper or lower half. It then issues a single-cycle write strobe to the bank.

## Interface
- `DATA_W`, 16, bank register width; must be even, minimum 16.
- `ADDR_W`, 4, bank address width (16 registers).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable samples required (10 ms at 50 MHz); minimum 2.

- `clk`  in  1  system clock (CLOCK_50 at top level).
- `reset`  in  1  asynchronous, active-high reset.
- `key_n`  in  1  raw push-button, active-low, asynchronous to `clk`.
- `sw_addr`  in  ADDR_W  target register address.
- `sw_byte`  in  8  data byte to write.
- `sw_hi`  in  1  1 = write byte into [DATA_W-1:DATA_W-8]; 0 = write byte into [7:0].
- `rd_addr`  out  ADDR_W  read address to the bank's spare read port.
- `rd_data`  in  DATA_W  bank read data; valid one cycle after `rd_addr` is stable.
- `wr_en`  out  1  bank write strobe (RW), one-cycle pulse.
- `wr_addr`  out  ADDR_W  bank write address.
- `wr_data`  out  DATA_W  bank write data.
- `busy`  out  1  high in every state except IDLE.
- `write_count`  out  8  number of completed writes, wraps 255→0.

## Operation
- `key_n` passes through a 2-flop synchronizer; the synchronizer flops reset to 1 (released). Its output is `key_s`.
- FSM states: IDLE, DEBOUNCE, READ1, READ2, WRITE, RELEASE.
- IDLE:
  - `key_s`=0 → DEBOUNCE, counter=1.
- DEBOUNCE:
  - `key_s`=1 → IDLE, counter=0 (bounce rejected, no capture).
  - `key_s`=0 and counter=DEBOUNCE_CYCLES-1 → capture `sw_addr`, `sw_byte`, `sw_hi` into holding registers, counter=0, → READ1.
  - Otherwise counter+1.
- READ1:
  - `rd_addr` is driven from the captured address; it is also held in all later states.
  - → READ2.
- READ2:
  - At the exit edge, `wr_data` is loaded with `rd_data` with the selected byte lane replaced by the captured byte. The other lane is preserved bit-exact.
  - `wr_addr` is loaded with the captured address.
  - → WRITE.
- WRITE:
  - `wr_en`=1 for exactly this cycle; `write_count`+1 at the exit edge.
  - → RELEASE.
- RELEASE:
  - Counts consecutive `key_s`=1 samples; any 0 clears the count.
  - Count reaches DEBOUNCE_CYCLES-1 with `key_s`=1 → IDLE.
- Exactly one write per press, however long the key is held. No new press is recognized until release has been debounced.
- Switch changes after capture have no effect on the write in progress.
- `wr_en` decodes as (state==WRITE); `busy` decodes as (state!=IDLE). `wr_addr`, `wr_data`, `rd_addr` and `write_count` are registered.

## Timing
- Reset values: state IDLE, counter 0, `wr_en` 0, `busy` 0, `wr_addr` 0, `wr_data` 0, `rd_addr` 0, `write_count` 0, holding registers 0.
- Reset asserted in any state aborts immediately: no `wr_en` pulse and no `write_count` change.
- `key_n` low → `key_s` low after 2 edges.
- Capture edge E is the DEBOUNCE_CYCLES-th consecutive `key_s`=0 sample.
- READ1 spans E to E+1; `rd_data` is sampled at E+2; `wr_en` is high between E+2 and E+3.
- `write_count` increments at E+3.
- `busy` rises at the edge entering DEBOUNCE. It falls at the edge returning to IDLE, whether from a bounce reject or at the end of RELEASE.
- `write_count` at 255 plus one write → 0.

## Test plan
- DEBOUNCE_CYCLES=4, bank reg 3 = 0x1234. Hold `key_n` low with `sw_addr`=3, `sw_byte`=0xAB, `sw_hi`=0 → one `wr_en` pulse, `wr_addr`=3, `wr_data`=0x12AB, `write_count`=1.
- Same setup with `sw_hi`=1 → `wr_data`=0xAB34; the lower byte is unchanged.
- Bounce: `key_n` low for 2 cycles, high for 1, low for 2, then high → no `wr_en`, `busy` returns to 0, `write_count` unchanged.
- Hold the key for 1000 cycles and change `sw_byte` to 0x55 after capture → exactly one `wr_en`, carrying the captured byte; a second press after release → second write, `write_count`=2.
- Assert `reset` during READ2 → no `wr_en`; all outputs return to reset values within the same cycle.
- 256 debounced presses → `write_count` wraps to 0 and `wr_en` is pulsed 256 times.
